ram_burst_master: RTL
=====================

# ram_burst_master

Initiator for the on-chip single-port RAM. Accepts burst read/write commands over a valid/ready command channel, streams write data in and read data out over valid/ready data channels, and drives the RAM's address, write-enable and data-in pins. It sits between a bus-side client and the RAM. It hides the RAM's registered-address read timing and provides back-pressure on both data channels.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 6, RAM address port width
- DEPTH, 32, RAM words; power of two, ≤ 2**ADDR_WIDTH
- LEN_WIDTH, 6, burst length field; beats = cmd_len + 1 (1..64)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  beats minus one
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_WIDTH  write beat
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_WIDTH  read beat
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at burst completion
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_data_in  out  DATA_WIDTH  to RAM data_in
- ram_write_enable  out  1  to RAM write_enable
- ram_data_out  in  DATA_WIDTH  from RAM data_out

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready:
  - latch the start address as cmd_addr mod DEPTH;
  - latch beats remaining = cmd_len + 1;
  - go to WRITE or READ according to cmd_write.
- WRITE:
  - wr_ready = 1 while beats remain.
  - Each accepted beat registers ram_address = current address, ram_data_in = wr_data, ram_write_enable = 1 for the next cycle.
  - After each beat, the address increments and beats remaining decrements.
  - After the last beat's RAM write cycle, go to DONE.
- READ:
  - Issue one address per cycle with ram_write_enable = 0, provided the 2-entry output buffer has room: occupancy + in-flight < 2.
  - One cycle after issue, capture ram_data_out into the buffer.
  - rd_valid = buffer not empty; rd_data = buffer head; the head pops on rd_valid && rd_ready.
  - When all beats are issued, captured and popped, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Address arithmetic: increment modulo DEPTH, so DEPTH-1 wraps to 0.
- Beats remaining is LEN_WIDTH+1 bits wide.
- ram_address holds its last value when not issuing. ram_write_enable = 0 outside WRITE beats.
- rd_ready low stalls address issue. ram_address is held, so the RAM read register stays stable during the stall.
- wr_valid low inserts idle cycles (ram_write_enable = 0) with no address advance.
- wr_valid in IDLE/READ and rd_ready in IDLE/WRITE are ignored.

## Timing
- Reset (asynchronous): state IDLE. cmd_ready = 1; all other outputs 0, including rd_data and the ram_* outputs. Buffer is emptied.
- Reset mid-burst aborts immediately: no done pulse, no further RAM writes.
- Write: beat accepted at edge E → ram_write_enable = 1 during cycle E+1 → RAM updated at edge ending E+1.
- Read: command accepted at edge T; first address issued during cycle T+1; data captured at edge ending T+2; rd_valid = 1 from cycle T+3.
- Read throughput is 1 beat/cycle with rd_ready held high.
- done is asserted the cycle after the last write edge, or after the last read pop. cmd_ready returns the cycle after done.
- A new command is never accepted while busy; there are no overlapping bursts.

## Structure
- Package ram_master_pkg: state enumeration (IDLE, WRITE, READ, DONE) and default widths DATA_WIDTH = 8, ADDR_WIDTH = 6, DEPTH = 32.
- Sub-module rd_skid_fifo: 2-entry FIFO with push, pop, full, empty and occupancy outputs. Used for the read output buffer.
- The top level contains the FSM, address/beat counters, in-flight flag and RAM output registers.

## Test plan
- Write burst: addr 0, len 2, data 10,11,AF with wr_valid continuous → writes land on cycles E+1; read burst addr 0, len 2 returns 10,11,AF; done pulses once per burst.
- Wrap: write addr 30, len 3, data 01..04 → words at addresses 30,31,0,1. Read back addr 30, len 3 returns 01..04.
- Read back-pressure: rd_ready toggled 1-0-0-1 during an 8-beat read → no beat lost or duplicated; at most 2 in buffer; ram_address stable while stalled.
- Write gaps: wr_valid low 3 cycles mid-burst → ram_write_enable = 0 and the address unchanged during the gap; final contents correct.
- Command gating: cmd_valid held high while busy → cmd_ready = 0 until the cycle after done; the second command starts then.
- Reset mid-read: assert reset on beat 2 of an 8-beat read → outputs return to reset values immediately; no done pulse; a following read works normally.

Source files
------------

// File: rtl/ram_master_pkg.sv
// Shared definitions for the RAM burst master.
// Holds the default parameter values and the controller state encodings.
package ram_master_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_LEN_WIDTH  = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that buffers RAM read data on its way to the client.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, push_data write side (a push is dropped if full and not popping)
//   pop, pop_data   read side; pop_data is the current head
//   full, empty     status flags
//   count           current occupancy (0..2)
module rd_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the on-chip single-port RAM.
// Accepts read/write burst commands, streams write beats into the RAM and
// read beats out through a 2-entry buffer that absorbs the one-cycle RAM
// read latency and client back-pressure.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/len  burst command channel (beats = len + 1)
//   wr_valid/ready/data             write data channel
//   rd_valid/ready/data             read data channel
//   busy, done                      status; done pulses once per burst
//   ram_address/data_in/write_enable, ram_data_out   RAM pins
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // DEPTH is a power of two, so modulo DEPTH is a mask.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH:0]    beats;
  logic                  in_flight;
  logic [1:0]            buf_count;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  accept;
  logic                  beat_ok;
  logic                  pop;
  logic                  issue;
  logic                  read_last;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  assign accept    = cmd_ready && cmd_valid;
  assign addr_next = (addr + 1'b1) & ADDR_MASK;

  assign wr_ready  = (state == ST_WRITE) && (beats != '0);
  assign beat_ok   = wr_valid && wr_ready;

  assign rd_valid  = !buf_empty;
  assign pop       = (state == ST_READ) && rd_valid && rd_ready;

  // A slot freed by this cycle's pop counts as room, which is what keeps
  // the read stream at one beat per cycle when rd_ready stays high.
  assign issue = (state == ST_READ) && (beats != '0) &&
                 (({1'b0, buf_count} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop}));

  // Leave READ on the edge that pops the final beat so done follows directly.
  assign read_last = (state == ST_READ) && (beats == '0) && !in_flight &&
                     (buf_empty || ((buf_count == 2'd1) && pop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      addr             <= '0;
      beats            <= '0;
      in_flight        <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
    end else begin
      in_flight        <= issue;
      ram_write_enable <= beat_ok;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr  <= cmd_addr & ADDR_MASK;
            beats <= {1'b0, cmd_len} + 1'b1;
            state <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (beat_ok) begin
            ram_address <= addr;
            ram_data_in <= wr_data;
            addr        <= addr_next;
            beats       <= beats - 1'b1;
          end else if (beats == '0) begin
            // The last beat's write cycle is the current one.
            state <= ST_DONE;
          end
        end
        ST_READ: begin
          if (issue) begin
            ram_address <= addr;
            addr        <= addr_next;
            beats       <= beats - 1'b1;
          end
          if (read_last) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  rd_skid_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_rd_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (in_flight),
    .push_data(ram_data_out),
    .pop      (pop),
    .pop_data (rd_data),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );

endmodule
